// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Sits directly in front of the data memory. It accepts one load/store request
// at a time from the core's memory stage and drives the memory's
// addr/din/memOp/we/dout interface.
//
// - An aligned access goes to memory as a single operation. The memory applies
//   sign/zero extension itself for aligned loads.
// - A misaligned halfword or word access is split into ascending byte accesses
//   at addr+i. The address wraps modulo 2^ADDR_WIDTH. Load bytes are
//   reassembled and then extended here.
// - An illegal op, or a misaligned access when ALLOW_MISALIGNED=0, completes
//   with respErr=1 and makes no memory access.
//
// Ports
//   clk        in   single clock; the memory's clkRd/clkWr share it
//   rstn       in   asynchronous active-low reset
//   reqValid   in   request present
//   reqReady   out  high only in IDLE; transfer on reqValid & reqReady
//   reqAddr    in   byte address
//   reqData    in   store data in bits [8n-1:0]
//   reqOp      in   0 B, 1 H, 2 W, 4 BU, 5 HU (3/6/7 illegal)
//   reqWe      in   1 = store (BU/HU stores are illegal)
//   respValid  out  one-cycle completion pulse
//   respData   out  extended load result; 0 for stores and errors
//   respErr    out  error flag, qualified by respValid
//   memAddr    out  memory byte address
//   memDin     out  memory write data
//   memOp      out  memory access size/extension
//   memWe      out  memory write enable (only in WRITE)
//   memDout    in   memory read data, valid the cycle after ISSUE
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [31:0]           reqData,
  input  logic [2:0]            reqOp,
  input  logic                  reqWe,
  output logic                  respValid,
  output logic [31:0]           respData,
  output logic                  respErr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memDin,
  output logic [2:0]            memOp,
  output logic                  memWe,
  input  logic [31:0]           memDout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Transaction context latched at accept time
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [31:0]           st_data;
  logic [2:0]            op_q;
  logic                  split_q;
  logic [1:0]            cnt;
  logic [31:0]           assembly;

  // Request decode, evaluated on the live request inputs in IDLE
  logic req_illegal;
  logic req_misal;
  logic req_err;

  always_comb begin
    req_illegal = 1'b0;
    req_misal   = 1'b0;
    case (reqOp)
      3'd0, 3'd4: req_misal = 1'b0;
      3'd1, 3'd5: req_misal = reqAddr[0];
      3'd2:       req_misal = |reqAddr[1:0];
      default:    req_illegal = 1'b1;
    endcase
    // BU/HU are load-only encodings
    if (reqWe && reqOp[2])
      req_illegal = 1'b1;
    req_err = req_illegal || (req_misal && (ALLOW_MISALIGNED == 1'b0));
  end

  // Index of the final access: 0 for a single aligned access,
  // 1 for a split halfword, 3 for a split word.
  logic [1:0] last_idx;
  logic       last;

  assign last_idx = split_q ? ((op_q[1:0] == 2'd2) ? 2'd3 : 2'd1) : 2'd0;
  assign last     = (cnt == last_idx);

  // Parameters of the next byte access in a split sequence
  logic [1:0]            nxt_idx;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [31:0]           st_shift;
  logic [31:0]           nxt_din;

  always_comb begin
    nxt_idx  = cnt + 2'd1;
    nxt_addr = base_addr + ADDR_WIDTH'(nxt_idx);
    st_shift = st_data >> {nxt_idx, 3'b000};
    nxt_din  = {24'b0, st_shift[7:0]};
  end

  // The byte returned in this CAPT merged into its lane of the assembly word.
  // Each lane is written exactly once after being cleared at accept.
  logic [31:0] asm_merged;

  assign asm_merged = assembly | ({24'b0, memDout[7:0]} << {cnt, 3'b000});

  // Extension of a reassembled split load. Byte ops never split.
  function automatic logic [31:0] extend_split(input logic [2:0]  op,
                                               input logic [31:0] asm_word);
    logic signed [15:0] half;
    logic [31:0]        ext;
    half = $signed(asm_word[15:0]);
    case (op)
      3'd1:    ext = {{16{half[15]}}, half};
      3'd5:    ext = {16'b0, asm_word[15:0]};
      default: ext = asm_word;
    endcase
    return ext;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (reqValid) begin
          if (req_err)
            state_nxt = RESP;
          else if (reqWe)
            state_nxt = WRITE;
          else
            state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = last ? RESP : ISSUE;
      WRITE:   state_nxt = last ? RESP : WRITE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign reqReady  = (state == IDLE);
  assign respValid = (state == RESP);
  assign memWe     = (state == WRITE);

  // ---------------------------------------------------------------------------
  // Context, memory-interface and response registers
  // ---------------------------------------------------------------------------
  // The memory interface registers advance to the next byte at the end of
  // each CAPT/WRITE. When the unit is idle they keep their last values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_addr <= '0;
      st_data   <= '0;
      op_q      <= 3'd2;
      split_q   <= 1'b0;
      cnt       <= 2'd0;
      assembly  <= '0;
      memAddr   <= '0;
      memDin    <= '0;
      memOp     <= 3'd2;
      respData  <= '0;
      respErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            base_addr <= reqAddr;
            st_data   <= reqData;
            op_q      <= reqOp;
            split_q   <= req_misal;
            cnt       <= 2'd0;
            assembly  <= '0;
            if (req_err) begin
              respErr  <= 1'b1;
              respData <= '0;
            end else begin
              respErr <= 1'b0;
              memAddr <= reqAddr;
              if (req_misal) begin
                memOp  <= reqWe ? 3'd0 : 3'd4;
                memDin <= {24'b0, reqData[7:0]};
              end else begin
                memOp  <= reqOp;
                memDin <= reqData;
              end
            end
          end
        end
        CAPT: begin
          assembly <= asm_merged;
          if (!last) begin
            cnt     <= nxt_idx;
            memAddr <= nxt_addr;
            memDin  <= nxt_din;
          end else begin
            // An aligned load is already extended by the memory
            respData <= split_q ? extend_split(op_q, asm_merged) : memDout;
          end
        end
        WRITE: begin
          if (!last) begin
            cnt     <= nxt_idx;
            memAddr <= nxt_addr;
            memDin  <= nxt_din;
          end else begin
            respData <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic [2:0]  reqOp;
  logic        reqWe;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] memAddr;
  logic [31:0] memDin;
  logic [2:0]  memOp;
  logic        memWe;
  logic [31:0] memDout;

  // Second instance with misaligned accesses disallowed
  logic        r2Valid;
  logic        r2Ready;
  logic [31:0] r2Addr;
  logic [31:0] r2Data;
  logic [2:0]  r2Op;
  logic        r2We;
  logic        r2RespValid;
  logic [31:0] r2RespData;
  logic        r2RespErr;
  logic [31:0] r2MemAddr;
  logic [31:0] r2MemDin;
  logic [2:0]  r2MemOp;
  logic        r2MemWe;
  logic [31:0] r2MemDout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .reqData(reqData),
    .reqOp(reqOp), .reqWe(reqWe),
    .respValid(respValid), .respData(respData), .respErr(respErr),
    .memAddr(memAddr), .memDin(memDin), .memOp(memOp), .memWe(memWe), .memDout(memDout)
  );

  load_store_unit #(.ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut2 (
    .clk(clk), .rstn(rstn),
    .reqValid(r2Valid), .reqReady(r2Ready), .reqAddr(r2Addr), .reqData(r2Data),
    .reqOp(r2Op), .reqWe(r2We),
    .respValid(r2RespValid), .respData(r2RespData), .respErr(r2RespErr),
    .memAddr(r2MemAddr), .memDin(r2MemDin), .memOp(r2MemOp), .memWe(r2MemWe), .memDout(r2MemDout)
  );

  // ---------------------------------------------------------------------------
  // Little-endian byte memory, 1 KiB, synchronous read and write
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  logic        bk_we = 1'b0;
  logic [9:0]  bk_addr = '0;
  logic [31:0] bk_data = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] op);
    logic [9:0]  i0, i1, i2, i3;
    logic [31:0] r;
    i0 = a[9:0]; i1 = i0 + 10'd1; i2 = i0 + 10'd2; i3 = i0 + 10'd3;
    case (op)
      3'd0:    r = {{24{mem[i0][7]}}, mem[i0]};
      3'd4:    r = {24'b0, mem[i0]};
      3'd1:    r = {{16{mem[i1][7]}}, mem[i1], mem[i0]};
      3'd5:    r = {16'b0, mem[i1], mem[i0]};
      default: r = {mem[i3], mem[i2], mem[i1], mem[i0]};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (bk_we) begin
      mem[bk_addr]         <= bk_data[7:0];
      mem[bk_addr + 10'd1] <= bk_data[15:8];
      mem[bk_addr + 10'd2] <= bk_data[23:16];
      mem[bk_addr + 10'd3] <= bk_data[31:24];
    end else if (memWe) begin
      mem[memAddr[9:0]] <= memDin[7:0];
      if (memOp == 3'd1 || memOp == 3'd2)
        mem[memAddr[9:0] + 10'd1] <= memDin[15:8];
      if (memOp == 3'd2) begin
        mem[memAddr[9:0] + 10'd2] <= memDin[23:16];
        mem[memAddr[9:0] + 10'd3] <= memDin[31:24];
      end
    end
    memDout <= mem_rd(memAddr, memOp);
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] w);
    bk_addr = a; bk_data = w; bk_we = 1'b1;
    @(posedge clk); #1;
    bk_we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction driver: records writes, latency and response (no checking)
  // ---------------------------------------------------------------------------
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_din  [0:7];
  int          nwr;

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op,
                        input logic we, output int lat, output logic [31:0] rd,
                        output logic er);
    int guard;
    guard = 0;
    nwr = 0;
    while (!reqReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    reqAddr = a; reqData = d; reqOp = op; reqWe = we; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 0; rd = 32'hx; er = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (memWe && nwr < 8) begin
        wr_addr[nwr] = memAddr;
        wr_din[nwr]  = memDin;
        nwr++;
      end
      if (respValid) begin
        lat = k; rd = respData; er = respErr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0;
    reqValid = 1'b0; reqAddr = '0; reqData = '0; reqOp = 3'd0; reqWe = 1'b0;
    r2Valid = 1'b0; r2Addr = '0; r2Data = '0; r2Op = 3'd0; r2We = 1'b0; r2MemDout = '0;
    #22;
    tests++; if (reqReady !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", reqReady); end
    tests++; if (respValid !== 1'b0) begin fails++; $display("FAIL reset_respValid got %b want 0", respValid); end
    tests++; if (respData !== 32'h0) begin fails++; $display("FAIL reset_respData got %h want 0", respData); end
    tests++; if (respErr !== 1'b0) begin fails++; $display("FAIL reset_respErr got %b want 0", respErr); end
    tests++; if (memWe !== 1'b0) begin fails++; $display("FAIL reset_memWe got %b want 0", memWe); end
    tests++; if (memAddr !== 32'h0) begin fails++; $display("FAIL reset_memAddr got %h want 0", memAddr); end
    tests++; if (memDin !== 32'h0) begin fails++; $display("FAIL reset_memDin got %h want 0", memDin); end
    tests++; if (memOp !== 3'd2) begin fails++; $display("FAIL reset_memOp got %0d want 2", memOp); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_load();
    int lat; logic [31:0] rd; logic er;
    preload(10'h100, 32'h8899AABB);
    do_req(32'h100, 32'h0, 3'd2, 1'b0, lat, rd, er);
    tests++; if (lat !== 3) begin fails++; $display("FAIL lw_lat got %0d want 3", lat); end
    tests++; if (rd !== 32'h8899AABB) begin fails++; $display("FAIL lw_data got %h want 8899aabb", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL lw_err got %b want 0", er); end
    do_req(32'h102, 32'h0, 3'd1, 1'b0, lat, rd, er);
    tests++; if (lat !== 3) begin fails++; $display("FAIL lh_lat got %0d want 3", lat); end
    tests++; if (rd !== 32'hFFFF8899) begin fails++; $display("FAIL lh_data got %h want ffff8899", rd); end
    do_req(32'h102, 32'h0, 3'd5, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'h00008899) begin fails++; $display("FAIL lhu_data got %h want 00008899", rd); end
    do_req(32'h103, 32'h0, 3'd0, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'hFFFFFF88 || lat !== 3) begin fails++; $display("FAIL lb_data got %h lat %0d want ffffff88 lat 3", rd, lat); end
    do_req(32'h101, 32'h0, 3'd4, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'h000000AA) begin fails++; $display("FAIL lbu_data got %h want 000000aa", rd); end
  endtask

  task automatic test_split_load();
    int lat; logic [31:0] rd; logic er;
    preload(10'h100, 32'h44332211);
    preload(10'h104, 32'h88776655);
    preload(10'h108, 32'h000000CC);
    do_req(32'h103, 32'h0, 3'd2, 1'b0, lat, rd, er);
    tests++; if (lat !== 9) begin fails++; $display("FAIL split_lw_lat got %0d want 9", lat); end
    tests++; if (rd !== 32'h77665544) begin fails++; $display("FAIL split_lw_data got %h want 77665544", rd); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL split_lw_err got %b want 0", er); end
    do_req(32'h101, 32'h0, 3'd1, 1'b0, lat, rd, er);
    tests++; if (lat !== 5) begin fails++; $display("FAIL split_lh_lat got %0d want 5", lat); end
    tests++; if (rd !== 32'h00003322) begin fails++; $display("FAIL split_lh_pos got %h want 00003322", rd); end
    do_req(32'h107, 32'h0, 3'd1, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'hFFFFCC88) begin fails++; $display("FAIL split_lh_neg got %h want ffffcc88", rd); end
    do_req(32'h107, 32'h0, 3'd5, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'h0000CC88) begin fails++; $display("FAIL split_lhu got %h want 0000cc88", rd); end
  endtask

  task automatic test_split_store();
    int lat; logic [31:0] rd; logic er;
    do_req(32'h1FF, 32'h0000BEEF, 3'd1, 1'b1, lat, rd, er);
    tests++; if (lat !== 3) begin fails++; $display("FAIL sh_split_lat got %0d want 3", lat); end
    tests++; if (nwr !== 2) begin fails++; $display("FAIL sh_split_nwr got %0d want 2", nwr); end
    tests++; if (wr_addr[0] !== 32'h1FF || wr_din[0] !== 32'hEF) begin fails++; $display("FAIL sh_split_w0 got %h/%h want 000001ff/000000ef", wr_addr[0], wr_din[0]); end
    tests++; if (wr_addr[1] !== 32'h200 || wr_din[1] !== 32'hBE) begin fails++; $display("FAIL sh_split_w1 got %h/%h want 00000200/000000be", wr_addr[1], wr_din[1]); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL sh_split_data got %h want 0", rd); end
    do_req(32'h1FF, 32'h0, 3'd5, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL sh_readback got %h want 0000beef", rd); end
    do_req(32'h301, 32'hDEADBEEF, 3'd2, 1'b1, lat, rd, er);
    tests++; if (lat !== 5 || nwr !== 4) begin fails++; $display("FAIL sw_split_lat got %0d/%0d want 5/4", lat, nwr); end
    tests++; if (wr_addr[3] !== 32'h304 || wr_din[3] !== 32'hDE) begin fails++; $display("FAIL sw_split_w3 got %h/%h want 00000304/000000de", wr_addr[3], wr_din[3]); end
    do_req(32'h301, 32'h0, 3'd2, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_readback got %h want deadbeef", rd); end
    // Address wraps past the top of the address space
    do_req(32'hFFFFFFFF, 32'h00001234, 3'd1, 1'b1, lat, rd, er);
    tests++; if (wr_addr[0] !== 32'hFFFFFFFF || wr_addr[1] !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h/%h want ffffffff/00000000", wr_addr[0], wr_addr[1]); end
  endtask

  task automatic test_aligned_store();
    int lat; logic [31:0] rd; logic er;
    do_req(32'h200, 32'h12345678, 3'd2, 1'b1, lat, rd, er);
    tests++; if (lat !== 2 || nwr !== 1) begin fails++; $display("FAIL sw_lat got %0d/%0d want 2/1", lat, nwr); end
    tests++; if (wr_addr[0] !== 32'h200 || wr_din[0] !== 32'h12345678) begin fails++; $display("FAIL sw_w0 got %h/%h want 00000200/12345678", wr_addr[0], wr_din[0]); end
    do_req(32'h200, 32'h0, 3'd2, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL sw_readback got %h want 12345678", rd); end
    do_req(32'h205, 32'h000000A5, 3'd0, 1'b1, lat, rd, er);
    tests++; if (lat !== 2) begin fails++; $display("FAIL sb_lat got %0d want 2", lat); end
    do_req(32'h205, 32'h0, 3'd4, 1'b0, lat, rd, er);
    tests++; if (rd !== 32'h000000A5) begin fails++; $display("FAIL sb_readback got %h want 000000a5", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    do_req(32'h100, 32'hFFFFFFFF, 3'd3, 1'b1, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1) begin fails++; $display("FAIL op3_err got lat %0d err %b want 1/1", lat, er); end
    tests++; if (nwr !== 0 || rd !== 32'h0) begin fails++; $display("FAIL op3_noacc got nwr %0d data %h want 0/0", nwr, rd); end
    do_req(32'h100, 32'h0, 3'd4, 1'b1, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1 || nwr !== 0) begin fails++; $display("FAIL sbu_err got lat %0d err %b nwr %0d want 1/1/0", lat, er, nwr); end
    do_req(32'h100, 32'h0, 3'd6, 1'b0, lat, rd, er);
    tests++; if (lat !== 1 || er !== 1'b1) begin fails++; $display("FAIL op6_err got lat %0d err %b want 1/1", lat, er); end
    do_req(32'h100, 32'h0, 3'd2, 1'b0, lat, rd, er);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL err_cleared got %b want 0", er); end
  endtask

  task automatic test_no_misaligned();
    r2Addr = 32'h102; r2Data = 32'h0; r2Op = 3'd2; r2We = 1'b0; r2Valid = 1'b1;
    @(posedge clk); #1;
    r2Valid = 1'b0;
    tests++; if (r2RespValid !== 1'b1 || r2RespErr !== 1'b1) begin fails++; $display("FAIL nomis_err got valid %b err %b want 1/1", r2RespValid, r2RespErr); end
    tests++; if (r2MemWe !== 1'b0 || r2MemAddr !== 32'h0) begin fails++; $display("FAIL nomis_noacc got we %b addr %h want 0/0", r2MemWe, r2MemAddr); end
    @(posedge clk); #1;
    tests++; if (r2Ready !== 1'b1) begin fails++; $display("FAIL nomis_ready got %b want 1", r2Ready); end
    r2Addr = 32'h100; r2Valid = 1'b1;
    @(posedge clk); #1;
    r2Valid = 1'b0;
    tests++; if (r2RespValid !== 1'b0 || r2MemAddr !== 32'h100) begin fails++; $display("FAIL nomis_aligned_issue got valid %b addr %h want 0/100", r2RespValid, r2MemAddr); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (r2RespValid !== 1'b1 || r2RespErr !== 1'b0) begin fails++; $display("FAIL nomis_aligned_resp got valid %b err %b want 1/0", r2RespValid, r2RespErr); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    reqAddr = 32'h0; reqOp = 3'd3; reqWe = 1'b0; reqValid = 1'b1;
    @(posedge clk); #1;
    tests++; if (reqReady !== 1'b0 || respValid !== 1'b1) begin fails++; $display("FAIL b2b_resp1 got ready %b valid %b want 0/1", reqReady, respValid); end
    @(posedge clk); #1;
    tests++; if (reqReady !== 1'b1 || respValid !== 1'b0) begin fails++; $display("FAIL b2b_idle got ready %b valid %b want 1/0", reqReady, respValid); end
    @(posedge clk); #1;
    reqValid = 1'b0;
    tests++; if (respValid !== 1'b1 || memWe !== 1'b0) begin fails++; $display("FAIL b2b_resp2 got valid %b we %b want 1/0", respValid, memWe); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    reqAddr = 32'h103; reqOp = 3'd2; reqWe = 1'b0; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;   // first CAPT
    @(posedge clk); #1;   // second ISSUE
    @(posedge clk); #1;   // second CAPT
    rstn = 1'b0;
    #1;
    tests++; if (reqReady !== 1'b1 || respValid !== 1'b0) begin fails++; $display("FAIL midrst_state got ready %b valid %b want 1/0", reqReady, respValid); end
    tests++; if (memAddr !== 32'h0 || memWe !== 1'b0) begin fails++; $display("FAIL midrst_mem got addr %h we %b want 0/0", memAddr, memWe); end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      tests++; if (respValid !== 1'b0 || reqReady !== 1'b1) begin fails++; $display("FAIL midrst_quiet got valid %b ready %b want 0/1", respValid, reqReady); end
    end
    do_req(32'h100, 32'h0, 3'd2, 1'b0, lat, rd, er);
    tests++; if (lat !== 3 || rd !== 32'h44332211) begin fails++; $display("FAIL midrst_after got lat %0d data %h want 3/44332211", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_aligned_load();
    test_split_load();
    test_split_store();
    test_aligned_store();
    test_errors();
    test_no_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
